bcd_seq_converter: RTL

Sequential double-dabble binary-to-BCD converter that sits between the neural network output register and the seven-segment display controller. It accepts the 12-bit network result through a valid/ready handshake and converts it iteratively, one bit per cycle. It then presents four registered BCD digits plus a leading-zero mask that stay stable between updates, so the multiplexed display never shows a partially converted value.

---
 rtl/bcd_seq_converter.sv | 113 +++++++++++
 1 files changed

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter with registered, display-stable digits and leading-zero mask.
// state | meaning:  IDLE | ready for a new value, outputs hold;  CONV | one add-3/shift step per cycle
module bcd_seq_converter #(
   parameter int WIDTH  = 12,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     lz_mask,
   output logic                  out_valid,
   output logic                  busy
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_bin;
   logic [BW-1:0]    r_bcd;
   logic [CW-1:0]    r_cnt;
   logic [BW-2:0]    w_bcd_adj;
   logic [3:0]       w_nib;
   logic [BW-1:0]    w_bcd_sh;
   logic [WIDTH-1:0] w_bin_sh;
   logic [DIGITS-1:0] w_lz;
   logic             w_all_zero;
   logic             w_last;
   logic             w_accept;

   // The adjusted top nibble's MSB is shifted out, so only its low 3 bits are kept.
   always_comb begin
      w_bcd_adj = '0;
      w_nib     = '0;
      for (int d = 0; d < DIGITS - 1; d++) begin
         w_nib = r_bcd[4*d +: 4];
         if (w_nib >= 4'd5) w_nib = w_nib + 4'd3;
         w_bcd_adj[4*d +: 4] = w_nib;
      end
      w_nib = r_bcd[4*(DIGITS-1) +: 4];
      if (w_nib >= 4'd5) w_nib = w_nib + 4'd3;
      w_bcd_adj[4*(DIGITS-1) +: 3] = w_nib[2:0];
   end

   assign {w_bcd_sh, w_bin_sh} = {w_bcd_adj, r_bin, 1'b0};
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_lz       = '0;
      w_all_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_all_zero = w_all_zero && (w_bcd_sh[4*k +: 4] == 4'd0);
         w_lz[k]    = w_all_zero;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CONV;
            end
         end
         S_CONV: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         bcd_out   <= '0;
         lz_mask   <= {{(DIGITS-1){1'b1}}, 1'b0};
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (w_accept) begin
            r_bin <= in_data;
            r_bcd <= '0;
            r_cnt <= '0;
         end else if (r_state == S_CONV) begin
            r_bin <= w_bin_sh;
            r_bcd <= w_bcd_sh;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
               bcd_out   <= w_bcd_sh;
               lz_mask   <= w_lz;
               out_valid <= 1'b1;
            end
         end
      end
   end
endmodule
